// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is registered.
module synchronous_fifo #(
   parameter int DEPTH         = 8,
   parameter int DATA_WIDTH    = 8,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 1,
   parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [CNT_WIDTH-1:0]  count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  err_clr
);

   localparam int                   PTR_W      = $clog2(DEPTH);
   localparam logic [PTR_W-1:0]     LAST_PTR   = PTR_W'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] AFULL_CNT  = CNT_WIDTH'(AFULL_THRESH);
   localparam logic [CNT_WIDTH-1:0] AEMPTY_CNT = CNT_WIDTH'(AEMPTY_THRESH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_acc, rd_acc;

   // Status decodes only from the registered count, never from the request inputs.
   assign full         = (count_q == FULL_CNT);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AFULL_CNT);
   assign almost_empty = (count_q <= AEMPTY_CNT);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = w_en && !full;
   assign rd_acc = r_en && !empty;

   always_comb begin
      // NOTE: every next-state value is given its hold value first so no path can infer a latch.
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (w_en && full) overflow_d = 1'b1;
      if (r_en && empty) underflow_d = 1'b1;

      if (wr_acc) wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
      if (rd_acc) rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_WIDTH'(1);
         2'b01:   count_d = count_q - CNT_WIDTH'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // NOTE: storage has no reset; empty masks every entry that has not been written since reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr_q] <= data_in;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : mem[rptr_q];
`else
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   assign rdata_d = rd_acc ? mem[rptr_q] : rdata_q;

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   assign data_out = rdata_q;
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Self-checking bench: two FIFO instances (DEPTH 8 and 6) share one stimulus stream and are
// compared every cycle against a queue-based model, plus directed literal expectations.
module tb_synchronous_fifo;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       w_en = 1'b0;
   logic       r_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] data_in = 8'h00;

   logic [7:0] dout8, dout6;
   logic [3:0] cnt8;
   logic [2:0] cnt6;
   logic       full8, empty8, af8, ae8, ovf8, unf8;
   logic       full6, empty6, af6, ae6, ovf6, unf6;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   synchronous_fifo #(.DEPTH(8), .DATA_WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1)) dut8 (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(dout8),
      .full(full8), .empty(empty8), .almost_full(af8), .almost_empty(ae8), .count(cnt8),
      .overflow(ovf8), .underflow(unf8), .err_clr(err_clr)
   );

   synchronous_fifo #(.DEPTH(6), .DATA_WIDTH(8), .AFULL_THRESH(4), .AEMPTY_THRESH(2)) dut6 (
      .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(dout6),
      .full(full6), .empty(empty6), .almost_full(af6), .almost_empty(ae6), .count(cnt6),
      .overflow(ovf6), .underflow(unf6), .err_clr(err_clr)
   );

`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   // ---------------- behavioural model: one queue per instance ----------------
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   bit         m_ovf [2];
   bit         m_unf [2];
   logic [7:0] m_dreg[2];

   function automatic int m_depth(int i);
      return (i == 0) ? 8 : 6;
   endfunction
   function automatic int m_afull(int i);
      return (i == 0) ? 6 : 4;
   endfunction
   function automatic int m_aempty(int i);
      return (i == 0) ? 1 : 2;
   endfunction
   function automatic int qsize(int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction
   function automatic logic [7:0] qhead(int i);
      if (qsize(i) == 0) return 8'h00;
      return (i == 0) ? q0[0] : q1[0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock edge's worth of request semantics to the model.
   task automatic model_edge();
      int  n;
      bit  fl, em;
      for (int i = 0; i < 2; i++) begin
         n  = qsize(i);
         fl = (n == m_depth(i));
         em = (n == 0);
         if (rst) begin
            if (i == 0) q0.delete(); else q1.delete();
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
            m_dreg[i] = 8'h00;
         end else begin
            if (err_clr) begin
               m_ovf[i] = 1'b0;
               m_unf[i] = 1'b0;
            end
            if (w_en && fl) m_ovf[i] = 1'b1;
            if (r_en && em) m_unf[i] = 1'b1;
            if (r_en && !em) begin
               if (i == 0) m_dreg[i] = q0.pop_front();
               else        m_dreg[i] = q1.pop_front();
            end
            if (w_en && !fl) begin
               if (i == 0) q0.push_back(data_in);
               else        q1.push_back(data_in);
            end
         end
      end
   endtask

   // ---------------- per-cycle compare process ----------------
   always @(negedge clk) begin
      logic [7:0] o_dout;
      logic [3:0] o_cnt;
      logic [5:0] o_flags, e_flags;
      logic [7:0] e_dout;
      int         n;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            o_dout  = (i == 0) ? dout8 : dout6;
            o_cnt   = (i == 0) ? cnt8 : {1'b0, cnt6};
            o_flags = (i == 0) ? {full8, empty8, af8, ae8, ovf8, unf8}
                               : {full6, empty6, af6, ae6, ovf6, unf6};
            n       = qsize(i);
            e_flags = {n == m_depth(i), n == 0, n >= m_afull(i), n <= m_aempty(i),
                       m_ovf[i], m_unf[i]};
            e_dout  = FWFT ? qhead(i) : m_dreg[i];
            check($sformatf("count[%0d]", i), 32'(o_cnt), n);
            check($sformatf("flags{full,empty,af,ae,ovf,unf}[%0d]", i), 32'(o_flags), 32'(e_flags));
            check($sformatf("data_out[%0d]", i), 32'(o_dout), 32'(e_dout));
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at a negedge: drive inputs, let the edge happen, update model, return at next negedge.
   task automatic step(input bit w, input logic [7:0] d, input bit r, input bit ec, input bit rs);
      w_en = w; data_in = d; r_en = r; err_clr = ec; rst = rs;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   // A read whose value is checked where each mode makes it visible.
   task automatic read_expect(input logic [7:0] v, input string name);
      if (FWFT) check(name, 32'(dout8), 32'(v));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      if (!FWFT) check(name, 32'(dout8), 32'(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      @(negedge clk);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      chk_en = 1'b1;
      repeat (3) idle();
      check("reset count", 32'(cnt8), 0);
      check("reset empty", 32'(empty8), 1);
      check("reset almost_empty", 32'(ae8), 1);
      check("reset full", 32'(full8), 0);
      check("reset data_out", 32'(dout8), 0);

      // Fill DEPTH=8 with 0x10..0x17.
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0);
         if (k == 4) check("almost_full at 5", 32'(af8), 0);
         if (k == 5) check("almost_full at 6", 32'(af8), 1);
         if (k == 6) check("full at 7", 32'(full8), 0);
      end
      check("full after 8", 32'(full8), 1);
      check("count after 8", 32'(cnt8), 8);

      // Ninth write while full, no read.
      step(1'b1, 8'h18, 1'b0, 1'b0, 1'b0);
      check("overflow set", 32'(ovf8), 1);
      check("count held at full", 32'(cnt8), 8);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("overflow cleared", 32'(ovf8), 0);

      // Ninth write while full with simultaneous read: only the read happens.
      if (FWFT) check("fwft head before read", 32'(dout8), 32'h10);
      step(1'b1, 8'h18, 1'b1, 1'b0, 1'b0);
      if (!FWFT) check("read during overflow", 32'(dout8), 32'h10);
      check("overflow with read", 32'(ovf8), 1);
      check("count after read at full", 32'(cnt8), 7);
      for (int k = 1; k < 8; k++) read_expect(8'(8'h10 + k), $sformatf("drain %0d", k));
      check("empty after drain", 32'(empty8), 1);
      if (FWFT) check("fwft zero when empty", 32'(dout8), 0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

      // Read while empty combined with a write of 0xAA.
      step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
      check("underflow set", 32'(unf8), 1);
      check("count after write on empty", 32'(cnt8), 1);
      read_expect(8'hAA, "read 0xAA");
      check("count after 0xAA read", 32'(cnt8), 0);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("underflow cleared", 32'(unf8), 0);

      // Reset mid-fill.
      for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b0);
      check("count mid-fill", 32'(cnt8), 5);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check("count after mid reset", 32'(cnt8), 0);
      check("empty after mid reset", 32'(empty8), 1);

      // Head visibility without a read request.
      step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      if (FWFT) check("fwft 0x55 visible", 32'(dout8), 32'h55);
      idle();
      if (FWFT) check("fwft 0x55 held", 32'(dout8), 32'h55);
      read_expect(8'h55, "read 0x55");
      if (FWFT) check("fwft zero after last read", 32'(dout8), 0);

      // DEPTH=6: prefill 3, then 20 cycles of simultaneous read+write across the pointer wrap.
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         step(1'b1, 8'(8'h40 + k), 1'b1, 1'b0, 1'b0);
         check($sformatf("d6 stream count %0d", k), 32'(cnt6), 3);
         if (FWFT)
            check($sformatf("d6 stream data %0d", k), 32'(dout6),
                  (k + 1 < 3) ? 32'(8'h30 + k + 1) : 32'(8'h40 + k - 2));
         else
            check($sformatf("d6 stream data %0d", k), 32'(dout6),
                  (k < 3) ? 32'(8'h30 + k) : 32'(8'h40 + k - 3));
      end

      // Randomized phases with shifting bias so both instances hit full and empty often.
      for (int ph = 0; ph < 6; ph++) begin
         int wp, rp;
         wp = (ph % 3 == 0) ? 75 : (ph % 3 == 1) ? 25 : 50;
         rp = 100 - wp;
         for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 99) < wp, 8'($urandom_range(0, 255)),
                 $urandom_range(0, 99) < rp, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 499) == 0);
         end
      end

      repeat (10) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      idle();
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
